// File: rtl/x_500_mod_241_frame_loader.sv
// Word-stream front end for a 500-bit mod-241 reducer: gathers up to 16 LE words,
// reduces the assembled operand in one cycle and hands the residue out on valid/ready.

module x_500_mod_241 (
    input  logic [499:0] x,
    output logic [7:0]   r
);
    // 256^k mod 241 per byte lane; a weighted byte sum keeps the final modulo narrow.
    function automatic logic [7:0] byte_weight(input int k);
        int w;
        w = 1;
        for (int i = 0; i < k; i++) w = (w * 256) % 241;
        return 8'(w);
    endfunction

    logic [503:0] x_pad;
    logic [21:0]  acc;

    assign x_pad = {4'b0, x};

    always_comb begin
        acc = '0;
        for (int k = 0; k < 63; k++)
            acc = acc + 22'(x_pad[8*k +: 8]) * 22'(byte_weight(k));
        r = 8'(acc % 22'd241);
    end
endmodule

module x_500_mod_241_frame_loader #(
    parameter int W_IN    = 32,
    parameter int N_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_r,
    output logic        out_err
);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t       state;
    logic [499:0] x;
    logic [3:0]   cnt;
    logic         err_lat;
    logic [7:0]   r;
    logic         beat;

    x_500_mod_241 u_red (.x(x), .r(r));

    assign beat = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            cnt       <= '0;
            err_lat   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (beat) begin
                        for (int k = 0; k < N_WORDS - 1; k++)
                            if (cnt == 4'(k)) x[W_IN*k +: W_IN] <= in_data;
                        // Last slot only carries the top 20 bits of the operand.
                        if (cnt == 4'(N_WORDS - 1)) x[499:480] <= in_data[19:0];
                        cnt <= cnt + 4'd1;
                        if (in_last || cnt == 4'(N_WORDS - 1)) begin
                            err_lat  <= !in_last;
                            in_ready <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    out_r     <= r;
                    out_err   <= err_lat;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        x         <= '0;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x_500_mod_241_frame_loader.sv
// Bench for the frame loader: vector table, hand-written corner sequences and
// random frames checked against a word-wise Horner reference.

module tb_x_500_mod_241_frame_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_r;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] frame_w [16];

    x_500_mod_241_frame_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  r;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // X = sum w_k * 2^(32k), top word truncated to 20 bits; reduced most-significant first.
    function automatic logic [7:0] model(input int n);
        longint unsigned acc;
        longint unsigned w;
        acc = 0;
        for (int k = n - 1; k >= 0; k--) begin
            w   = (k == 15) ? longint'(frame_w[k] & 32'h000F_FFFF) : longint'(frame_w[k]);
            acc = (acc * 64'h1_0000_0000 + w) % 241;
        end
        return 8'(acc);
    endfunction

    // Called and returns at a negedge; the accepting posedge lies in between.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int t;
        t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("beat_accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [7:0] er, input logic ee);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_r"}, longint'(out_r), longint'(er));
        check({name, "_err"}, longint'(out_err), longint'(ee));
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_drop"}, longint'(out_valid), 0);
    endtask

    task automatic send_frame(input int n, input logic with_last);
        for (int k = 0; k < n; k++)
            send_beat(frame_w[k], (k == n - 1) ? with_last : 1'b0);
    endtask

    initial begin
        vec_t vecs [6];
        logic [7:0] held;
        int n;
        logic wl;

        vecs[0] = '{32'd0,          8'd0};
        vecs[1] = '{32'd241,        8'd0};
        vecs[2] = '{32'd240,        8'd240};
        vecs[3] = '{32'hFFFF_FFFF,  8'd14};
        vecs[4] = '{32'd482,        8'd0};
        vecs[5] = '{32'd1000,       8'd36};

        // Reset state
        #2;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_r", longint'(out_r), 0);
        check("rst_out_err", longint'(out_err), 0);
        @(negedge clk);
        rst = 1'b0;
        check("idle_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        check("load_in_ready", longint'(in_ready), 1);

        // Zero frame latency: CALC after acceptance, valid one edge later
        send_beat(32'd0, 1'b1);
        check("zero_lat_calc", longint'(out_valid), 0);
        check("zero_lat_inrdy", longint'(in_ready), 0);
        @(negedge clk);
        check("zero_lat_valid", longint'(out_valid), 1);
        get_result("zero", 8'd0, 1'b0);
        check("zero_inrdy_back", longint'(in_ready), 1);

        // Single-beat table
        for (int i = 0; i < 6; i++) begin
            send_beat(vecs[i].d, 1'b1);
            get_result($sformatf("vec%0d", i), vecs[i].r, 1'b0);
        end

        // Full frame of ones, in_last on beat 16
        for (int k = 0; k < 16; k++) frame_w[k] = 32'hFFFF_FFFF;
        send_frame(16, 1'b1);
        get_result("full", 8'd225, 1'b0);

        // Missing in_last, then a short frame proving X was cleared
        for (int k = 0; k < 16; k++) frame_w[k] = 32'd0;
        frame_w[0] = 32'd5;
        send_frame(16, 1'b0);
        get_result("nolast", 8'd5, 1'b1);
        send_beat(32'd7, 1'b1);
        get_result("after_nolast", 8'd7, 1'b0);

        // Backpressure in DONE with a word waiting
        out_ready = 1'b0;
        send_beat(32'd1234, 1'b1);
        @(negedge clk);
        held = out_r;
        check("bp_first", longint'(held), 1234 % 241);
        in_data  = 32'd99;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_r_stable", longint'(out_r), longint'(held));
            check("bp_valid", longint'(out_valid), 1);
            check("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", longint'(out_valid), 0);
        check("bp_in_ready_back", longint'(in_ready), 1);
        send_beat(32'd7, 1'b1);
        get_result("bp_next", 8'd7, 1'b0);

        // Reset mid-frame
        for (int k = 0; k < 5; k++) send_beat(32'hDEAD_0000 + 32'(k), 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", longint'(in_ready), 0);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        send_beat(32'd482, 1'b1);
        get_result("post_rst", 8'd0, 1'b0);

        // Random frames vs reference
        for (int f = 0; f < 30; f++) begin
            n  = int'($urandom_range(1, 16));
            wl = (n == 16) ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int k = 0; k < 16; k++) frame_w[k] = (k < n) ? $urandom : 32'd0;
            send_frame(n, wl);
            get_result($sformatf("rand%0d", f), model(n), !wl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end
endmodule
